// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares one single-ported unified instruction/data memory between the fetch
// stage (read-only) and the memory stage (read/write). One access is in
// flight at a time; the data port wins from IDLE, and after a completion the
// other port is granted directly, so two busy requesters alternate.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, an access that sees no mem_ready for TIMEOUT_CYCLES busy
//   cycles is aborted and completes with i_err/d_err set and read data 0.
//   When undefined, the arbiter waits indefinitely for mem_ready.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   i_req/i_addr        fetch read request (held until i_done)
//   i_rdata/i_done      fetched word and one-cycle completion pulse
//   d_req/d_we/d_be     data request, store select, store byte enables
//   d_addr/d_wdata      data address and store data
//   d_rdata/d_done      load data and one-cycle completion pulse
//   i_err/d_err         (ARB_TIMEOUT_EN only) completion was a timeout abort
//   stall_if/stall_mem  combinational stalls to the hazard unit
//   mem_req..mem_wdata  registered memory command
//   mem_rdata/mem_ready memory response
//   dbg_state           current FSM state (IDLE=0, D_BUSY=1, I_BUSY=2)
//
// Handshake: a requester raises req with stable address/data and holds them
// until its done pulse; done and rdata are registered and valid for exactly
// that one cycle. The req seen during the done cycle is ignored, and a req
// still high in the following cycle is a new request. On the memory side the
// command is held stable while mem_req=1 and the access completes on the
// rising edge where mem_ready=1; mem_ready is ignored while mem_req=0.

module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
`ifdef ARB_TIMEOUT_EN
    output logic              i_err,
    output logic              d_err,
`endif
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] D_BUSY = 2'd1;
    localparam logic [1:0] I_BUSY = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       i_pend;
    logic       d_pend;
    logic       busy;
    logic       ok_done;
    logic       timeout;
    logic       finish;
    logic       grant_i;
    logic       grant_d;

    // A requester's req is masked during its own done cycle so it can drop
    // req combinationally from done without launching a second access.
    assign i_pend = i_req & ~i_done;
    assign d_pend = d_req & ~d_done;

    assign stall_if  = i_pend;
    assign stall_mem = d_pend;

    assign busy      = (state == D_BUSY) || (state == I_BUSY);
    assign mem_req   = busy;
    assign dbg_state = state;

    assign ok_done = busy & mem_ready;
    assign finish  = ok_done | timeout;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;

    // The count holds the number of busy cycles already spent without
    // mem_ready, so the abort fires on the edge ending busy cycle
    // TIMEOUT_CYCLES.
    assign timeout = busy & ~mem_ready &
                     (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (grant_i || grant_d) begin
            tmo_cnt <= '0;
        end else if (busy && !mem_ready) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i_err <= 1'b0;
            d_err <= 1'b0;
        end else begin
            i_err <= timeout & (state == I_BUSY);
            d_err <= timeout & (state == D_BUSY);
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // Grant selection. At a completion edge the finishing port's own req is
    // still the request being served (it is held until done), so only the
    // other port can be granted without passing through IDLE.
    always_comb begin
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (d_pend) begin
                    grant_d = 1'b1;
                end else if (i_pend) begin
                    grant_i = 1'b1;
                end
            end
            D_BUSY: begin
                if (finish) begin
                    grant_i = i_pend;
                end
            end
            I_BUSY: begin
                if (finish) begin
                    grant_d = d_pend;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (grant_d) begin
            state_next = D_BUSY;
        end else if (grant_i) begin
            state_next = I_BUSY;
        end else if (finish) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            state  <= state_next;
            i_done <= finish & (state == I_BUSY);
            d_done <= finish & (state == D_BUSY);

            if (state == I_BUSY) begin
                if (ok_done) begin
                    i_rdata <= mem_rdata;
                end else if (timeout) begin
                    i_rdata <= '0;
                end
            end

            // Stores complete with d_done but leave the load data untouched.
            if ((state == D_BUSY) && !mem_we) begin
                if (ok_done) begin
                    d_rdata <= mem_rdata;
                end else if (timeout) begin
                    d_rdata <= '0;
                end
            end

            if (grant_d) begin
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_we    <= d_we;
                mem_be    <= d_we ? d_be : 4'b0000;
            end else if (grant_i) begin
                mem_addr  <= i_addr;
                mem_wdata <= '0;
                mem_we    <= 1'b0;
                mem_be    <= 4'b0000;
            end else if (finish) begin
                mem_we <= 1'b0;
                mem_be <= 4'b0000;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// -------------------
// Directed bench for mem_port_arbiter: a table of single transactions with
// hand-computed expectations, plus hand-written sequences for simultaneous
// requests, alternation, mid-access reset and (with ARB_TIMEOUT_EN) the
// timeout abort. Inputs are driven at the falling edge; outputs are sampled
// 1 time unit after the falling edge.

module tb_mem_port_arbiter;

    localparam logic [31:0] MEM_KEY = 32'hA5A5_0000;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
`ifdef ARB_TIMEOUT_EN
    logic        i_err;
    logic        d_err;
`endif
    logic        stall_if;
    logic        stall_mem;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [1:0]  dbg_state;

    int checks;
    int errors;
    logic [31:0] exp_q[$];

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_req(i_req),
        .i_addr(i_addr),
        .i_rdata(i_rdata),
        .i_done(i_done),
        .d_req(d_req),
        .d_we(d_we),
        .d_be(d_be),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_rdata(d_rdata),
        .d_done(d_done),
`ifdef ARB_TIMEOUT_EN
        .i_err(i_err),
        .d_err(d_err),
`endif
        .stall_if(stall_if),
        .stall_mem(stall_mem),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_be(mem_be),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        is_d;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem_data;
        int          waits;
        int          exp_lat;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_be      = 4'b0000;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Driver: one transaction from a table record, with a wait-state model.
    task automatic run_vec(input vec_t v, input int idx);
        int          cyc;
        int          waits_left;
        bit          done_seen;
        bit          first;
        bit          stable;
        bit          stall_ok;
        logic [31:0] c_addr;
        logic [31:0] c_wdata;
        logic        c_we;
        logic [3:0]  c_be;
        c_addr = '0; c_wdata = '0; c_we = 1'b0; c_be = 4'b0000;
        @(negedge clk);
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        mem_ready  = 1'b0;
        waits_left = v.waits;
        cyc        = 0;
        done_seen  = 1'b0;
        first      = 1'b1;
        stable     = 1'b1;
        stall_ok   = 1'b1;
        while (!done_seen && cyc < 50) begin
            #1;
            if ((v.is_d ? stall_mem : stall_if) !== 1'b1) stall_ok = 1'b0;
            if (mem_req === 1'b1) begin
                if (first) begin
                    c_addr = mem_addr; c_wdata = mem_wdata; c_we = mem_we; c_be = mem_be;
                    first = 1'b0;
                end else if (c_addr !== mem_addr || c_wdata !== mem_wdata ||
                             c_we !== mem_we || c_be !== mem_be) begin
                    stable = 1'b0;
                end
                if (waits_left > 0) begin
                    mem_ready = 1'b0; mem_rdata = ~v.mem_data; waits_left--;
                end else begin
                    mem_ready = 1'b1; mem_rdata = v.mem_data;
                end
            end else begin
                mem_ready = 1'b0;
            end
            @(negedge clk);
            cyc++;
            done_seen = v.is_d ? d_done : i_done;
        end
        mem_ready = 1'b0;
        #1;
        check($sformatf("v%0d_latency", idx), cyc, v.exp_lat);
        check($sformatf("v%0d_rdata", idx), v.is_d ? d_rdata : i_rdata, v.exp_rdata);
        check($sformatf("v%0d_mem_addr", idx), c_addr, v.addr);
        check($sformatf("v%0d_mem_we", idx), {31'b0, c_we}, {31'b0, v.exp_we});
        check($sformatf("v%0d_mem_be", idx), {28'b0, c_be}, {28'b0, v.exp_be});
        if (v.exp_we) check($sformatf("v%0d_mem_wdata", idx), c_wdata, v.wdata);
        check($sformatf("v%0d_stable", idx), {31'b0, stable}, 32'd1);
        check($sformatf("v%0d_stall_busy", idx), {31'b0, stall_ok}, 32'd1);
        check($sformatf("v%0d_stall_done", idx), {31'b0, v.is_d ? stall_mem : stall_if}, 32'd0);
`ifdef ARB_TIMEOUT_EN
        check($sformatf("v%0d_err", idx), {31'b0, v.is_d ? d_err : i_err}, 32'd0);
`endif
        // req is left high through the done cycle; it must not start a new access.
        @(negedge clk);
        #1;
        check($sformatf("v%0d_done_pulse", idx), {31'b0, v.is_d ? d_done : i_done}, 32'd0);
        check($sformatf("v%0d_no_regrant", idx), {31'b0, mem_req}, 32'd0);
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic seq_simultaneous();
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_0100;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'b0000; d_addr = 32'h0000_2000;
        mem_ready = 1'b1;   // ignored while IDLE
        #1;
        check("sim_c0_stall_if", {31'b0, stall_if}, 32'd1);
        check("sim_c0_stall_mem", {31'b0, stall_mem}, 32'd1);
        @(negedge clk); #1;
        check("sim_c1_mem_req", {31'b0, mem_req}, 32'd1);
        check("sim_c1_mem_addr", mem_addr, 32'h0000_2000);
        check("sim_c1_state", {30'b0, dbg_state}, 32'd1);
        mem_rdata = mem_addr ^ MEM_KEY;
        @(negedge clk); #1;
        check("sim_c2_d_done", {31'b0, d_done}, 32'd1);
        check("sim_c2_d_rdata", d_rdata, 32'hA5A5_2000);
        check("sim_c2_mem_req", {31'b0, mem_req}, 32'd1);
        check("sim_c2_mem_addr", mem_addr, 32'h0000_0100);
        check("sim_c2_state", {30'b0, dbg_state}, 32'd2);
        check("sim_c2_stall_if", {31'b0, stall_if}, 32'd1);
        d_req = 1'b0;
        mem_rdata = mem_addr ^ MEM_KEY;
        @(negedge clk); #1;
        check("sim_c3_i_done", {31'b0, i_done}, 32'd1);
        check("sim_c3_i_rdata", i_rdata, 32'hA5A5_0100);
        check("sim_c3_stall_if", {31'b0, stall_if}, 32'd0);
        check("sim_c3_mem_req", {31'b0, mem_req}, 32'd0);
        i_req = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
    endtask

    // Scoreboard: expected mem_addr of each grant, in order.
    task automatic seq_alternation();
        int          dcnt;
        int          icnt;
        int          grants;
        logic [31:0] exp_addr;
        dcnt = 0; icnt = 0; grants = 0;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(32'h0000_2000);
            exp_q.push_back(32'h0000_0100);
        end
        @(negedge clk);
        i_addr = 32'h0000_0100; d_addr = 32'h0000_2000; d_we = 1'b0; d_be = 4'b0000;
        i_req = 1'b1; d_req = 1'b1; mem_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (mem_req === 1'b1) begin
                mem_rdata = mem_addr ^ MEM_KEY;
                grants++;
                if (exp_q.size() != 0) begin
                    exp_addr = exp_q.pop_front();
                    check("alt_grant_order", mem_addr, exp_addr);
                end
            end
            @(negedge clk);
            if (d_done) dcnt++;
            if (i_done) icnt++;
            if (dcnt >= 3) d_req = 1'b0;
            if (icnt >= 3) i_req = 1'b0;
            if (dcnt >= 3 && icnt >= 3) break;
        end
        i_req = 1'b0; d_req = 1'b0;
        check("alt_d_dones", dcnt, 32'd3);
        check("alt_i_dones", icnt, 32'd3);
        check("alt_grants", grants, 32'd6);
        check("alt_queue_empty", exp_q.size(), 32'd0);
        #1;
        check("alt_d_rdata", d_rdata, 32'hA5A5_2000);
        check("alt_i_rdata", i_rdata, 32'hA5A5_0100);
        @(negedge clk); #1;
        check("alt_idle_after", {31'b0, mem_req}, 32'd0);
        mem_ready = 1'b0;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic seq_timeout();
        int busy_cycles;
        int cyc;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_0500; mem_ready = 1'b0; mem_rdata = 32'h5555_AAAA;
        busy_cycles = 0;
        cyc = 0;
        while (!i_done && cyc < 30) begin
            #1;
            if (mem_req === 1'b1) busy_cycles++;
            @(negedge clk);
            cyc++;
        end
        #1;
        check("tmo_busy_cycles", busy_cycles, 32'd4);
        check("tmo_done_cycle", cyc, 32'd5);
        check("tmo_i_done", {31'b0, i_done}, 32'd1);
        check("tmo_i_err", {31'b0, i_err}, 32'd1);
        check("tmo_i_rdata", i_rdata, 32'd0);
        check("tmo_mem_req", {31'b0, mem_req}, 32'd0);
        i_req = 1'b0;
        @(negedge clk); #1;
        check("tmo_err_pulse", {31'b0, i_err}, 32'd0);
    endtask
`endif

    task automatic seq_reset_mid_access();
        bit quiet;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b1111; d_addr = 32'h0000_4000;
        d_wdata = 32'h0BAD_F00D; mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check("rst_pre_mem_req", {31'b0, mem_req}, 32'd1);
        reset = 1'b1;
        d_req = 1'b0;
        @(negedge clk); #1;
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_state", {30'b0, dbg_state}, 32'd0);
        check("rst_d_done", {31'b0, d_done}, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        reset = 1'b0;
        mem_ready = 1'b1;
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk); #1;
            if (d_done !== 1'b0 || i_done !== 1'b0 || mem_req !== 1'b0) quiet = 1'b0;
        end
        check("rst_no_done_after", {31'b0, quiet}, 32'd1);
        mem_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //          is_d  we    be      addr           wdata          mem_data       wt lat exp_we exp_be   exp_rdata
        vecs[0] = '{1'b0, 1'b0, 4'h0,   32'h0000_0100, 32'h0,         32'h0050_0093, 0, 2, 1'b0, 4'h0,    32'h0050_0093};
        vecs[1] = '{1'b1, 1'b0, 4'hF,   32'h0000_2000, 32'h1111_1111, 32'h1234_5678, 1, 3, 1'b0, 4'h0,    32'h1234_5678};
        vecs[2] = '{1'b1, 1'b1, 4'b0011, 32'h0000_2004, 32'hDEAD_BEEF, 32'hAAAA_5555, 3, 5, 1'b1, 4'b0011, 32'h1234_5678};
        vecs[3] = '{1'b0, 1'b0, 4'h0,   32'h0000_0104, 32'h0,         32'hFFFF_FFFF, 2, 4, 1'b0, 4'h0,    32'hFFFF_FFFF};
        vecs[4] = '{1'b1, 1'b0, 4'h0,   32'h0000_3000, 32'h0,         32'h0000_0000, 0, 2, 1'b0, 4'h0,    32'h0000_0000};
        vecs[5] = '{1'b1, 1'b1, 4'hF,   32'h0000_3004, 32'h0102_0304, 32'h7777_7777, 0, 2, 1'b1, 4'hF,    32'h0000_0000};

        apply_reset();
        #1;
        check("reset_mem_req", {31'b0, mem_req}, 32'd0);
        check("reset_state", {30'b0, dbg_state}, 32'd0);
        check("reset_i_done", {31'b0, i_done}, 32'd0);
        check("reset_d_done", {31'b0, d_done}, 32'd0);
        check("reset_i_rdata", i_rdata, 32'd0);
        check("reset_d_rdata", d_rdata, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        check("reset_mem_we_be", {27'b0, mem_we, mem_be}, 32'd0);
        check("reset_stalls", {30'b0, stall_if, stall_mem}, 32'd0);

        for (int n = 0; n < 6; n++) begin
            run_vec(vecs[n], n);
        end

        seq_simultaneous();
        seq_alternation();
`ifdef ARB_TIMEOUT_EN
        seq_timeout();
`endif
        seq_reset_mid_access();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
